// File: rtl/fdma_wr_arbiter_n.sv
// N-channel FDMA write arbiter: grants one upstream channel per burst, muxes its
// address/size/data onto the shared FDMA port and checks delivered beats against size.
module fdma_wr_arbiter_n #(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                           I_fdma_clk,
  input  logic                           I_fdma_rstn,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]   I_fdma_waddr,
  input  logic [CH_NUM-1:0]              I_fdma_wareq,
  input  logic [CH_NUM*16-1:0]           I_fdma_wsize,
  output logic [CH_NUM-1:0]              O_fdma_wbusy,
  input  logic [CH_NUM*DATA_WIDTH-1:0]   I_fdma_wdata,
  output logic [CH_NUM-1:0]              O_fdma_wvalid,
  output logic [ADDR_WIDTH-1:0]          O_fdma_waddr,
  output logic                           O_fdma_wareq,
  output logic [15:0]                    O_fdma_wsize,
  output logic [DATA_WIDTH-1:0]          O_fdma_wdata,
  input  logic                           I_fdma_wbusy,
  input  logic                           I_fdma_wvalid,
  output logic [$clog2(CH_NUM)-1:0]      O_grant_id,
  output logic                           O_len_err
);

  localparam int unsigned GW = $clog2(CH_NUM);

  typedef enum logic [1:0] {IDLE, REQ, BUSY, DONE} state_t;

  state_t                  state, state_nxt;
  logic [15:0]             beat_cnt, beat_nxt;
  logic [GW-1:0]           winner;
  logic                    grant_go, beat_inc, burst_end;
  int unsigned             gid, rank, best;

  logic [ADDR_WIDTH-1:0]   addr_arr [CH_NUM];
  logic [15:0]             size_arr [CH_NUM];
  logic [DATA_WIDTH-1:0]   data_arr [CH_NUM];

  for (genvar g = 0; g < CH_NUM; g++) begin : g_unpack
    assign addr_arr[g] = I_fdma_waddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign size_arr[g] = I_fdma_wsize[g*16 +: 16];
    assign data_arr[g] = I_fdma_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Each channel gets a rank (distance after the last grant, or its own index in
  // fixed-priority mode); the lowest-ranked requester wins.
  always_comb begin
    winner = O_grant_id;
    gid    = 32'(O_grant_id);
    rank   = 0;
    best   = CH_NUM;
    for (int unsigned j = 0; j < CH_NUM; j++) begin
      if (ARB_MODE != 0)
        rank = j;
      else
        rank = (j > gid) ? (j - gid - 1) : (j + CH_NUM - gid - 1);
      if (I_fdma_wareq[j] && (rank < best)) begin
        best   = rank;
        winner = GW'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if ((|I_fdma_wareq) && !I_fdma_wbusy) state_nxt = REQ;
      REQ:     if (I_fdma_wbusy) state_nxt = BUSY;
      BUSY:    if (!I_fdma_wbusy) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_go  = (state == IDLE) && (state_nxt == REQ);
  assign beat_inc  = (state == BUSY) && I_fdma_wvalid;
  assign burst_end = (state == BUSY) && !I_fdma_wbusy;
  // A beat arriving on the same cycle wbusy drops still counts toward the length check.
  assign beat_nxt  = beat_cnt + 16'(beat_inc);

  always_ff @(posedge I_fdma_clk or negedge I_fdma_rstn) begin
    if (!I_fdma_rstn) begin
      state        <= IDLE;
      O_fdma_wareq <= 1'b0;
      O_grant_id   <= GW'(CH_NUM - 1);
      O_fdma_waddr <= '0;
      O_fdma_wsize <= '0;
      beat_cnt     <= '0;
      O_len_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      O_fdma_wareq <= (state_nxt == REQ);
      if (grant_go) begin
        O_grant_id   <= winner;
        O_fdma_waddr <= addr_arr[winner];
        O_fdma_wsize <= size_arr[winner];
        beat_cnt     <= '0;
      end else if (beat_inc) begin
        beat_cnt <= beat_nxt;
      end
      if (burst_end && (beat_nxt != O_fdma_wsize))
        O_len_err <= 1'b1;
    end
  end

  always_comb begin
    O_fdma_wbusy  = '0;
    O_fdma_wvalid = '0;
    for (int unsigned j = 0; j < CH_NUM; j++) begin
      if (O_grant_id == GW'(j)) begin
        O_fdma_wbusy[j]  = (state == REQ) || (state == BUSY);
        O_fdma_wvalid[j] = (state == BUSY) && I_fdma_wvalid;
      end
    end
  end

  assign O_fdma_wdata = data_arr[O_grant_id];

endmodule
